// File: rtl/muldiv_unit.sv
// ---------------------------------------------------------------------------
// muldiv_unit
//   Multi-cycle multiply/divide unit with architectural HI/LO registers.
//   The full result is computed and captured into a temp register when an
//   operation is accepted; the unit then stays busy for a fixed latency
//   (MULT_LAT or DIV_LAT) and commits the temp into HI/LO on the last count.
//
// Handshake: an op is accepted on a rising edge where start=1, i.e.
//   op_valid=1, op is a defined code (001..110), the unit is IDLE and
//   cancel=0. There is no back-pressure beyond that: requests seen while
//   busy, with an undefined op, or under cancel are dropped, not queued.
//
// Ports
//   clk      : rising-edge clock
//   reset    : asynchronous active-high reset
//   op_valid : operation request
//   op       : 001 mult, 010 multu, 011 div, 100 divu, 101 madd, 110 msub
//   src_a    : rs operand
//   src_b    : rt operand
//   cancel   : exception flush (aborts an operation in flight)
//   wr_hi    : mthi, writes wr_data into HI when idle
//   wr_lo    : mtlo, writes wr_data into LO when idle
//   wr_data  : mthi/mtlo data
//   start    : combinational, op accepted this cycle
//   busy     : registered, operation in flight
//   done     : registered one-cycle pulse after commit
//   hi, lo   : HI/LO registers
// ---------------------------------------------------------------------------
module muldiv_unit #(
    parameter int WIDTH    = 32,
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             op_valid,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             cancel,
    input  logic             wr_hi,
    input  logic             wr_lo,
    input  logic [WIDTH-1:0] wr_data,
    output logic             start,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int CW      = $clog2(MAX_LAT + 1);

    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MADD  = 3'b101;
    localparam logic [2:0] OP_MSUB  = 3'b110;

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state;
    logic [CW-1:0]      cnt;
    logic               div_class;
    logic [2*WIDTH-1:0] temp;
    logic               done_r;
    logic [WIDTH-1:0]   hi_r;
    logic [WIDTH-1:0]   lo_r;

    logic               op_defined;
    logic               is_div_op;

    assign op_defined = (op != 3'b000) && (op != 3'b111);
    assign is_div_op  = (op == OP_DIV) || (op == OP_DIVU);
    assign start      = op_valid && op_defined && (state == IDLE) && !cancel;

    assign busy = (state == RUN);
    assign done = done_r;
    assign hi   = hi_r;
    assign lo   = lo_r;

    // Result datapath. Multiply-class results are {hi,lo}; divide-class
    // results are held as {quotient, remainder} and swapped at commit.
    logic [2*WIDTH-1:0]        acc;
    logic signed [2*WIDTH-1:0] prod_s;
    logic [2*WIDTH-1:0]        prod_u;
    logic                      div_zero;
    logic                      div_ovf;
    logic [WIDTH-1:0]          div_b;
    logic signed [WIDTH-1:0]   quot_s;
    logic signed [WIDTH-1:0]   rem_s;
    logic [WIDTH-1:0]          quot_u;
    logic [WIDTH-1:0]          rem_u;
    logic [2*WIDTH-1:0]        result;

    always_comb begin
        acc    = {hi_r, lo_r};
        prod_s = $signed({{WIDTH{src_a[WIDTH-1]}}, src_a}) *
                 $signed({{WIDTH{src_b[WIDTH-1]}}, src_b});
        prod_u = {{WIDTH{1'b0}}, src_a} * {{WIDTH{1'b0}}, src_b};

        div_zero = (src_b == '0);
        div_ovf  = (src_a == {1'b1, {(WIDTH-1){1'b0}}}) && (src_b == '1);
        // Substituting a divisor of 1 keeps the divider away from the
        // undefined cases; MIN/1 is exactly the MIN/-1 result (q=MIN, r=0).
        div_b  = (div_zero || div_ovf) ? WIDTH'(1) : src_b;
        quot_s = $signed(src_a) / $signed(div_b);
        rem_s  = $signed(src_a) % $signed(div_b);
        quot_u = src_a / div_b;
        rem_u  = src_a % div_b;

        result = '0;
        case (op)
            OP_MULT:  result = prod_s;
            OP_MULTU: result = prod_u;
            OP_MADD:  result = acc + prod_s;
            OP_MSUB:  result = acc - prod_s;
            OP_DIV:   result = div_zero ? {{WIDTH{1'b1}}, src_a} : {quot_s, rem_s};
            OP_DIVU:  result = div_zero ? {{WIDTH{1'b1}}, src_a} : {quot_u, rem_u};
            default:  result = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            div_class <= 1'b0;
            temp      <= '0;
            done_r    <= 1'b0;
            hi_r      <= '0;
            lo_r      <= '0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    // mthi/mtlo land even when an op is accepted in the same
                    // cycle; the accumulator already sampled the old HI/LO.
                    if (!cancel) begin
                        if (wr_hi) hi_r <= wr_data;
                        if (wr_lo) lo_r <= wr_data;
                    end
                    if (start) begin
                        state     <= RUN;
                        cnt       <= is_div_op ? CW'(DIV_LAT) : CW'(MULT_LAT);
                        div_class <= is_div_op;
                        temp      <= result;
                    end
                end
                RUN: begin
                    if (cancel) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (cnt == CW'(1)) begin
                        state  <= IDLE;
                        cnt    <= '0;
                        done_r <= 1'b1;
                        if (div_class) begin
                            hi_r <= temp[WIDTH-1:0];
                            lo_r <= temp[2*WIDTH-1:WIDTH];
                        end else begin
                            hi_r <= temp[2*WIDTH-1:WIDTH];
                            lo_r <= temp[WIDTH-1:0];
                        end
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// ---------------------------------------------------------------------------
// tb_muldiv_unit
//   Directed bench for muldiv_unit with hand-computed expected values.
//   Inputs are driven and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_muldiv_unit;

    logic        clk;
    logic        reset;
    logic        op_valid;
    logic [2:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        cancel;
    logic        wr_hi;
    logic        wr_lo;
    logic [31:0] wr_data;
    logic        start;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int errors = 0;

    muldiv_unit #(.WIDTH(32), .MULT_LAT(5), .DIV_LAT(10)) dut (
        .clk(clk), .reset(reset), .op_valid(op_valid), .op(op),
        .src_a(src_a), .src_b(src_b), .cancel(cancel),
        .wr_hi(wr_hi), .wr_lo(wr_lo), .wr_data(wr_data),
        .start(start), .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    // clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one op and follow it through to its done pulse. With now=1 the
    // op is driven in the current (done) cycle for back-to-back issue.
    task automatic do_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] b, input int lat,
                         input logic [31:0] e_hi, input logic [31:0] e_lo, input bit now);
        int n;
        if (!now) @(negedge clk);
        op_valid = 1'b1; op = o; src_a = a; src_b = b;
        #1 chk({tag, "_start"}, 32'(start), 32'd1);
        @(negedge clk);
        chk({tag, "_start_busy"}, 32'(start), 32'd0);
        chk({tag, "_busy1"}, 32'(busy), 32'd1);
        chk({tag, "_done_low"}, 32'(done), 32'd0);
        op_valid = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            n++;
            @(negedge clk);
        end
        chk({tag, "_lat"}, 32'(n), 32'(lat));
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_hi"}, hi, e_hi);
        chk({tag, "_lo"}, lo, e_lo);
    endtask

    task automatic write_reg(input logic whi, input logic wlo, input logic [31:0] d);
        @(negedge clk);
        wr_hi = whi; wr_lo = wlo; wr_data = d;
        @(negedge clk);
        wr_hi = 1'b0; wr_lo = 1'b0;
    endtask

    initial begin
        int n;
        int dones;
        reset = 1'b1; op_valid = 1'b0; op = 3'b000; src_a = '0; src_b = '0;
        cancel = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0; wr_data = '0;

        // reset state
        #2;
        chk("rst_hi", hi, 32'h0);
        chk("rst_lo", lo, 32'h0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_start", 32'(start), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // multiply class
        do_op("mult", 3'b001, 32'hFFFF_FFFE, 32'd3, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 0);
        @(negedge clk);
        chk("mult_done_clr", 32'(done), 32'd0);
        do_op("multu", 3'b010, 32'hFFFF_FFFE, 32'd3, 5, 32'h0000_0002, 32'hFFFF_FFFA, 0);

        // divide class and corner cases
        do_op("div", 3'b011, 32'd7, 32'hFFFF_FFFE, 10, 32'h0000_0001, 32'hFFFF_FFFD, 0);
        do_op("divu0", 3'b100, 32'd5, 32'd0, 10, 32'h0000_0005, 32'hFFFF_FFFF, 0);
        do_op("divovf", 3'b011, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0, 32'h8000_0000, 0);
        do_op("divneg", 3'b011, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0);
        do_op("div0", 3'b011, 32'hFFFF_FFFB, 32'd0, 10, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 0);

        // mthi/mtlo then accumulate
        write_reg(1'b1, 1'b0, 32'd0);
        write_reg(1'b0, 1'b1, 32'd10);
        chk("mthi", hi, 32'd0);
        chk("mtlo", lo, 32'd10);
        do_op("madd", 3'b101, 32'd3, 32'd4, 5, 32'd0, 32'd22, 0);
        do_op("msub", 3'b110, 32'd5, 32'd5, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0);

        // back-to-back issue in the done cycle
        do_op("divu", 3'b100, 32'd100, 32'd7, 10, 32'd2, 32'd14, 0);
        do_op("b2b", 3'b001, 32'd6, 32'd7, 5, 32'd0, 32'd42, 1);

        // cancel at busy cycle 4, with ignored request and write while busy
        @(negedge clk);
        op_valid = 1'b1; op = 3'b011; src_a = 32'd100; src_b = 32'd3;
        #1 chk("cxl_start", 32'(start), 32'd1);
        @(negedge clk);                      // busy cycle 1
        op_valid = 1'b0;
        @(negedge clk);                      // busy cycle 2
        op_valid = 1'b1; op = 3'b001; src_a = 32'd9; src_b = 32'd9;
        #1 chk("busy_ign_start", 32'(start), 32'd0);
        @(negedge clk);                      // busy cycle 3
        op_valid = 1'b0;
        wr_hi = 1'b1; wr_lo = 1'b1; wr_data = 32'hDEAD_BEEF;
        @(negedge clk);                      // busy cycle 4
        wr_hi = 1'b0; wr_lo = 1'b0;
        chk("cxl_busy4", 32'(busy), 32'd1);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        chk("cxl_busy_clr", 32'(busy), 32'd0);
        chk("cxl_hi", hi, 32'd0);
        chk("cxl_lo", lo, 32'd42);
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            if (done === 1'b1) dones++;
            @(negedge clk);
        end
        chk("cxl_no_done", 32'(dones), 32'd0);
        chk("cxl_hi_late", hi, 32'd0);
        chk("cxl_lo_late", lo, 32'd42);

        // undefined op codes
        op_valid = 1'b1; op = 3'b000;
        #1 chk("op000_start", 32'(start), 32'd0);
        @(negedge clk);
        op = 3'b111;
        #1 chk("op111_start", 32'(start), 32'd0);
        @(negedge clk);
        op_valid = 1'b0;
        chk("undef_busy", 32'(busy), 32'd0);

        // write and start in the same cycle: madd must use {0,42}
        op_valid = 1'b1; op = 3'b101; src_a = 32'd1; src_b = 32'd1;
        wr_hi = 1'b1; wr_lo = 1'b1; wr_data = 32'h0000_0100;
        #1 chk("wrst_start", 32'(start), 32'd1);
        @(negedge clk);
        op_valid = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0;
        chk("wrst_hi_wr", hi, 32'h100);
        chk("wrst_lo_wr", lo, 32'h100);
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            n++;
            @(negedge clk);
        end
        chk("wrst_lat", 32'(n), 32'd5);
        chk("wrst_done", 32'(done), 32'd1);
        chk("wrst_hi", hi, 32'd0);
        chk("wrst_lo", lo, 32'd43);

        // asynchronous reset in the middle of a mult
        @(negedge clk);
        op_valid = 1'b1; op = 3'b001; src_a = 32'hFFFF_FFFE; src_b = 32'd3;
        @(negedge clk);
        op_valid = 1'b0;
        @(negedge clk);
        #3 reset = 1'b1;
        #1;
        chk("arst_hi", hi, 32'h0);
        chk("arst_lo", lo, 32'h0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        dones = 0;
        for (int i = 0; i < 10; i++) begin
            if (done === 1'b1) dones++;
            @(negedge clk);
        end
        chk("arst_no_done", 32'(dones), 32'd0);
        chk("arst_hi_late", hi, 32'h0);
        chk("arst_lo_late", lo, 32'h0);
        chk("arst_busy_late", 32'(busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Safety net so a wedged run still ends.
    initial begin
        #200000;
        $display("FAIL timeout observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
